spi_peripheral: RTL and testbench

//  SPI target (mode 0, write-only) that receives register writes from an external controller.

---
 rtl/spi_peripheral.sv | 132 +++++++++++++
 tb/tb_spi_peripheral.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// SPI target, mode 0, write-only. Receives 16-bit register write frames
// (R/W, 7-bit address, 8-bit data, MSB first) and holds the five control
// registers that configure the PWM block. SPI pins are asynchronous to clk.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam logic [6:0] MaxAddr = 7'(MAX_ADDR);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic                   sclk_prev_q, ncs_prev_q;
  logic                   sclk_s, copi_s, ncs_s;
  logic                   sclk_rise, ncs_rise;

  state_e      state_q;
  logic [4:0]  bit_cnt_q;
  logic        overflow_q;
  logic [15:0] shift_q;
  logic [7:0]  out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic        wr_strobe_q;

  logic [6:0]  frame_addr;
  logic [7:0]  frame_data;
  logic        frame_ok;

  // Synchronise the SPI pins; the extra prev flops give edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  // Synced pin values, edge strobes and decoded frame fields.
  always_comb begin
    sclk_s     = sclk_sync_q[SYNC_STAGES-1];
    copi_s     = copi_sync_q[SYNC_STAGES-1];
    ncs_s      = ncs_sync_q[SYNC_STAGES-1];
    sclk_rise  = sclk_s & ~sclk_prev_q;
    ncs_rise   = ncs_s & ~ncs_prev_q;
    frame_addr = shift_q[14:8];
    frame_data = shift_q[7:0];
    frame_ok   = (bit_cnt_q == 5'd16) && !overflow_q && shift_q[15] && (frame_addr <= MaxAddr);
  end

  // Frame reception FSM with registered register file and write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      shift_q     <= '0;
      out_lo_q    <= '0;
      out_hi_q    <= '0;
      pwm_lo_q    <= '0;
      pwm_hi_q    <= '0;
      duty_q      <= '0;
      wr_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!ncs_s) begin
            state_q    <= StShift;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
          end
        end
        StShift: begin
          // End of frame wins over a coincident SCLK rise.
          if (ncs_rise) begin
            state_q <= StCommit;
          end else if (sclk_rise) begin
            shift_q <= {shift_q[14:0], copi_s};
            if (bit_cnt_q < 5'd16) begin
              bit_cnt_q <= bit_cnt_q + 5'd1;
            end else begin
              overflow_q <= 1'b1;
            end
          end
        end
        StCommit: begin
          state_q <= StIdle;
          if (frame_ok) begin
            wr_strobe_q <= 1'b1;
            case (frame_addr)
              7'd0:    out_lo_q <= frame_data;
              7'd1:    out_hi_q <= frame_data;
              7'd2:    pwm_lo_q <= frame_data;
              7'd3:    pwm_hi_q <= frame_data;
              7'd4:    duty_q   <= frame_data;
              default: ;
            endcase
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign wr_strobe       = wr_strobe_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: table of directed frames plus
// hand-written latency, idle-SCLK, mid-frame reset and back-to-back sequences.
module tb_spi_peripheral;

  localparam int Half = 3;  // clk periods per SCLK phase (minimum allowed)

  logic       clk = 1'b0;
  logic       rst_n, sclk, copi, ncs;
  logic [7:0] r0, r1, r2, r3, r4;
  logic       wr_strobe;
  logic [39:0] all_regs;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  assign all_regs = {r4, r3, r2, r1, r0};

  // Count strobe pulses (value before each edge).
  always @(posedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  typedef struct {
    logic [31:0] frame;
    int          nbits;
    logic [39:0] regs;     // {r4,r3,r2,r1,r0}
    int          strobes;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive ncs low and clock out nbits of val MSB first; ncs is left low.
  task automatic shift_bits(input logic [31:0] val, input int nbits);
    @(negedge clk);
    ncs = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = val[i];
      repeat (Half) @(negedge clk);
      sclk = 1'b1;
      repeat (Half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (Half) @(negedge clk);
  endtask

  task automatic end_frame(input int gap);
    ncs = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    logic [39:0] model;
    logic [4:0]  got;
    int          base;
    int          exp_strobes;
    logic [6:0]  addr;
    logic        rw;
    logic [7:0]  data;

    rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_regs", 64'(all_regs), 64'h0);
    check("reset_strobe", 64'(wr_strobe), 64'h0);

    vecs[0]  = '{32'h80F0,  16, 40'h00_00_00_00_F0, 1};
    vecs[1]  = '{32'h82CC,  16, 40'h00_00_CC_00_F0, 1};
    vecs[2]  = '{32'h8480,  16, 40'h80_00_CC_00_F0, 1};
    vecs[3]  = '{32'h0055,  16, 40'h80_00_CC_00_F0, 0};  // read
    vecs[4]  = '{32'h8555,  16, 40'h80_00_CC_00_F0, 0};  // addr 5
    vecs[5]  = '{32'hFF00,  16, 40'h80_00_CC_00_F0, 0};  // addr 0x7F
    vecs[6]  = '{32'h40D5,  15, 40'h80_00_CC_00_F0, 0};  // short 0x81AA
    vecs[7]  = '{32'h10354, 17, 40'h80_00_CC_00_F0, 0};  // long 0x81AA
    vecs[8]  = '{32'h81AA,  16, 40'h80_00_CC_AA_F0, 1};
    vecs[9]  = '{32'h80F0,  16, 40'h80_00_CC_AA_F0, 1};  // same value
    vecs[10] = '{32'h83FF,  16, 40'h80_FF_CC_AA_F0, 1};

    for (int v = 0; v < 11; v++) begin
      base = strobe_cnt;
      shift_bits(vecs[v].frame, vecs[v].nbits);
      end_frame(8);
      check($sformatf("vec%0d_regs", v), 64'(all_regs), 64'(vecs[v].regs));
      check($sformatf("vec%0d_strobes", v), 64'(strobe_cnt - base), 64'(vecs[v].strobes));
    end

    // Latency: strobe exactly at the 4th clk after raw ncs rises, one cycle wide.
    shift_bits(32'h8233, 16);
    ncs = 1'b1;
    got = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      got = {got[3:0], wr_strobe};
      if (k == 3) check("lat_before", 64'(all_regs), 64'h80_FF_CC_AA_F0);
      if (k == 4) check("lat_at", 64'(all_regs), 64'h80_FF_33_AA_F0);
    end
    check("lat_strobe_pattern", 64'(got), 64'b00010);
    repeat (4) @(negedge clk);

    // SCLK toggling with ncs high is ignored.
    base = strobe_cnt;
    for (int i = 0; i < 16; i++) begin
      copi = 1'b1;
      repeat (Half) @(negedge clk);
      sclk = 1'b1;
      repeat (Half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    check("idle_sclk_regs", 64'(all_regs), 64'h80_FF_33_AA_F0);
    check("idle_sclk_strobes", 64'(strobe_cnt - base), 64'h0);

    // Reset after bit 9 of a 0x83FF frame.
    shift_bits(32'h83FF >> 6, 10);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset_regs", 64'(all_regs), 64'h0);
    check("midreset_strobe", 64'(wr_strobe), 64'h0);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    base = strobe_cnt;
    shift_bits(32'h8312, 16);
    end_frame(8);
    check("post_reset_regs", 64'(all_regs), 64'h00_12_00_00_00);
    check("post_reset_strobes", 64'(strobe_cnt - base), 64'h1);

    // Back-to-back random frames at minimum timing against a register model.
    model = 40'h00_12_00_00_00;
    base = strobe_cnt;
    exp_strobes = 0;
    for (int f = 0; f < 12; f++) begin
      addr = 7'($urandom_range(0, 6));
      rw   = ($urandom_range(0, 3) != 0);
      data = 8'($urandom);
      shift_bits({16'h0, rw, addr, data}, 16);
      end_frame(4);
      if (rw && addr <= 7'd4) begin
        model[addr*8 +: 8] = data;
        exp_strobes++;
      end
      check($sformatf("b2b%0d_regs", f), 64'(all_regs), 64'(model));
    end
    repeat (4) @(negedge clk);
    check("b2b_strobes", 64'(strobe_cnt - base), 64'(exp_strobes));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
